// File: rtl/if_network_pkg.sv
// Shared constants, state encoding and sizing helpers for the integrate-and-fire network.
package if_network_pkg;

  localparam int DEF_NUM_INPUTS  = 4;
  localparam int DEF_NUM_OUTPUTS = 1;
  localparam int DEF_THRESH      = 15;
  localparam int DEF_RESET       = 0;
  localparam int DEF_REFRAC      = 5;
  localparam int DEF_WEIGHT_SIZE = 32;

  typedef enum logic [0:0] {
    ST_INTEG  = 1'b0,
    ST_REFRAC = 1'b1
  } neuron_state_e;

  // Wide enough that v plus every weight can never wrap before saturation.
  function automatic int acc_width(input int num_inputs, input int weight_size);
    return weight_size + $clog2(num_inputs) + 1;
  endfunction

  function automatic int cnt_width(input int refrac);
    return (refrac > 0) ? $clog2(refrac + 1) : 1;
  endfunction

  // LSB position of W[j][i] inside the flattened weight vector.
  function automatic int weight_offset(input int j, input int i,
                                       input int num_inputs, input int weight_size);
    return (j * num_inputs + i) * weight_size;
  endfunction

endpackage

// File: rtl/if_neuron.sv
// One integrate-and-fire neuron: saturating weighted accumulation, threshold spike,
// reset to RESET and a fixed refractory window during which inputs are ignored.
module if_neuron
  import if_network_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int THRESH      = DEF_THRESH,
  parameter int RESET       = DEF_RESET,
  parameter int REFRAC      = DEF_REFRAC,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_INPUTS-1:0]             spike_i,
  input  logic [NUM_INPUTS*WEIGHT_SIZE-1:0] weights_i,
  output logic                              spike_o
);

  localparam int ACC_W = acc_width(NUM_INPUTS, WEIGHT_SIZE);
  localparam int CNT_W = cnt_width(REFRAC);
  localparam int EXT_W = ACC_W - WEIGHT_SIZE;

  localparam logic [ACC_W-1:0]       SAT_MAX  = {{EXT_W{1'b0}}, {WEIGHT_SIZE{1'b1}}};
  localparam logic [ACC_W-1:0]       THRESH_A = ACC_W'(THRESH);
  localparam logic [WEIGHT_SIZE-1:0] RESET_V  = WEIGHT_SIZE'(RESET);
  localparam logic [CNT_W-1:0]       REFRAC_C = CNT_W'(REFRAC);

  neuron_state_e            state_q, state_d;
  logic [WEIGHT_SIZE-1:0]   v_q, v_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     spike_q, spike_d;
  logic [ACC_W-1:0]         sum_s;
  logic [WEIGHT_SIZE-1:0]   sat_s;
  logic                     fire_s;

  // Weighted sum of active inputs onto the present potential, clamped to the register range.
  always_comb begin
    sum_s = {{EXT_W{1'b0}}, v_q};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      sum_s = sum_s + (spike_i[i] ? {{EXT_W{1'b0}}, weights_i[i*WEIGHT_SIZE +: WEIGHT_SIZE]}
                                  : {ACC_W{1'b0}});
    end
    if (sum_s > SAT_MAX) begin
      sat_s = {WEIGHT_SIZE{1'b1}};
    end else begin
      sat_s = sum_s[WEIGHT_SIZE-1:0];
    end
    fire_s = ({{EXT_W{1'b0}}, sat_s} >= THRESH_A);
  end

  // Next-state logic: integrate/fire while idle, count down while refractory.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    case (state_q)
      ST_INTEG: begin
        if (fire_s) begin
          spike_d = 1'b1;
          v_d     = RESET_V;
          cnt_d   = REFRAC_C;
          state_d = (REFRAC > 0) ? ST_REFRAC : ST_INTEG;
        end else begin
          v_d     = sat_s;
        end
      end
      ST_REFRAC: begin
        v_d   = RESET_V;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_INTEG;
        end else begin
          state_d = ST_REFRAC;
        end
      end
      default: begin
        state_d = ST_INTEG;
        v_d     = RESET_V;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, potential, refractory counter and output spike registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INTEG;
      v_q     <= RESET_V;
      cnt_q   <= {CNT_W{1'b0}};
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/if_network.sv
// Single fully connected layer of independent IF neurons; each neuron receives
// its own row of the flattened constant weight matrix.
module if_network
  import if_network_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int THRESH      = DEF_THRESH,
  parameter int RESET       = DEF_RESET,
  parameter int REFRAC      = DEF_REFRAC,
  parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
  parameter logic [NUM_OUTPUTS*NUM_INPUTS*WEIGHT_SIZE-1:0] WEIGHTS =
    {(NUM_OUTPUTS*NUM_INPUTS){WEIGHT_SIZE'(1)}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  spike_in,
  output logic [NUM_OUTPUTS-1:0] spike_out
);

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_neuron
    logic [NUM_INPUTS*WEIGHT_SIZE-1:0] w_row_s;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_w
      assign w_row_s[i*WEIGHT_SIZE +: WEIGHT_SIZE] =
        WEIGHTS[weight_offset(j, i, NUM_INPUTS, WEIGHT_SIZE) +: WEIGHT_SIZE];
    end

    if_neuron #(
      .NUM_INPUTS (NUM_INPUTS),
      .THRESH     (THRESH),
      .RESET      (RESET),
      .REFRAC     (REFRAC),
      .WEIGHT_SIZE(WEIGHT_SIZE)
    ) u_neuron (
      .clk_i    (clk),
      .rst_ni   (rst),
      .spike_i  (spike_in),
      .weights_i(w_row_s),
      .spike_o  (spike_out[j])
    );
  end

endmodule

// File: tb/tb_if_network.sv
// Directed bench for if_network: three configurations share clock, reset and inputs;
// an integer reference model feeds a scoreboard, plus hand-derived spike-timing checks.
module tb_if_network;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [3:0] spike_in = 4'b0000;
  logic [0:0] out_def;
  logic [0:0] out_r0;
  logic [1:0] out_w;

  always #5 clk = ~clk;

  if_network u_dut_def (
    .clk(clk), .rst(rst), .spike_in(spike_in), .spike_out(out_def)
  );

  if_network #(.THRESH(1), .REFRAC(0)) u_dut_r0 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .spike_out(out_r0)
  );

  if_network #(
    .NUM_OUTPUTS(2), .WEIGHT_SIZE(4), .REFRAC(2), .WEIGHTS(32'h4705_8321)
  ) u_dut_w (
    .clk(clk), .rst(rst), .spike_in(spike_in), .spike_out(out_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb_q[$];
  int th[4] = '{15, 1, 15, 15};
  int rf[4] = '{5, 0, 2, 2};
  int ws[4] = '{32, 32, 4, 4};
  int w[4][4] = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}, '{1, 2, 3, 8}, '{5, 0, 7, 4}};
  longint m_v[4];
  int     m_c[4];

  int ecount;
  int first2;
  int cnt[4];
  int edges0[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_v[n] = 0;
      m_c[n] = 0;
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] s, output logic [3:0] e);
    longint sum;
    longint sat;
    e = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      if (!r) begin
        m_v[n] = 0;
        m_c[n] = 0;
      end else if (m_c[n] > 0) begin
        m_c[n]--;
        m_v[n] = 0;
      end else begin
        sum = m_v[n];
        for (int i = 0; i < 4; i++) if (s[i]) sum += w[n][i];
        sat = (longint'(1) << ws[n]) - 1;
        if (sum > sat) sum = sat;
        if (sum >= th[n]) begin
          e[n]   = 1'b1;
          m_v[n] = 0;
          m_c[n] = rf[n];
        end else begin
          m_v[n] = sum;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] s);
    logic [3:0] e;
    logic [3:0] obs;
    @(negedge clk);
    rst      = r;
    spike_in = s;
    if (!r) begin
      #1;
      model_reset();
      check("async_reset_clear", {28'd0, out_w, out_r0, out_def}, 32'd0);
      ecount = 0;
    end
    model_edge(r, s, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    obs = {out_w, out_r0, out_def};
    if (r) begin
      ecount++;
      if (obs[0]) edges0.push_back(ecount);
      if (obs[2] && first2 == 0) first2 = ecount;
      for (int n = 0; n < 4; n++) cnt[n] += int'(obs[n]);
    end
    check("scoreboard", {28'd0, obs}, {28'd0, sb_q.pop_front()});
  endtask

  task automatic run(input logic r, input logic [3:0] s, input int n);
    repeat (n) step(r, s);
  endtask

  task automatic clr();
    edges0.delete();
    first2 = 0;
    for (int n = 0; n < 4; n++) cnt[n] = 0;
  endtask

  task automatic check_edges(input string tag, input int n, input int e1, input int e2, input int e3);
    int ex[3];
    int got;
    ex = '{e1, e2, e3};
    check({tag, "_count"}, edges0.size(), n);
    for (int k = 0; k < n; k++) begin
      got = (k < edges0.size()) ? edges0[k] : -1;
      check({tag, "_edge"}, got, ex[k]);
    end
  endtask

  initial begin
    // Reset held with all inputs active, then all-ones input: period 4 + 5 refractory
    run(1'b0, 4'b1111, 5);
    clr();
    run(1'b1, 4'b1111, 22);
    check_edges("all_inputs", 3, 4, 13, 22);

    // Single held input: spikes at 15 and 35; REFRAC=0/THRESH=1 fires every cycle
    run(1'b0, 4'b0000, 1);
    clr();
    run(1'b1, 4'b0001, 40);
    check_edges("single_input", 2, 15, 35, 0);
    check("refrac0_every_cycle", cnt[1], 40);

    // Potential carries over between different input lines
    run(1'b0, 4'b0000, 1);
    clr();
    run(1'b1, 4'b0001, 10);
    run(1'b1, 4'b0010, 10);
    run(1'b1, 4'b0100, 10);
    run(1'b1, 4'b1000, 10);
    check_edges("carry_over", 2, 15, 35, 0);

    // Reset two cycles into the refractory window leaves no refractory residue
    run(1'b0, 4'b0000, 1);
    clr();
    run(1'b1, 4'b1111, 6);
    check_edges("pre_mid_reset", 1, 4, 0, 0);
    step(1'b0, 4'b1111);
    clr();
    run(1'b1, 4'b1111, 4);
    check_edges("post_mid_reset", 1, 4, 0, 0);

    // 4-bit potential: 12 + 8 saturates to 15 and fires instead of wrapping to 4
    run(1'b0, 4'b0000, 1);
    clr();
    run(1'b1, 4'b0100, 4);
    run(1'b1, 4'b1000, 1);
    check("saturate_fire_edge", first2, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
